// File: rtl/sig_bank_pkg.sv
// rtl/sig_bank_pkg.sv - shared types, sizes and helpers for the signature bank sequencer
package sig_bank_pkg;

    localparam int WIDTH = 10;
    localparam int BANKS = 3;

    localparam logic [BANKS-1:0] PHASE_RST = {{(BANKS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        ARMED,
        SCAN
    } state_t;

    // Rotate the low n bits of v left by one, wrapping bit n-1 into bit 0.
    function automatic logic [31:0] rotl1(input logic [31:0] v, input int n);
        logic [31:0] mask;
        mask = (32'd1 << n) - 32'd1;
        return ((v << 1) | (v >> (n - 1))) & mask;
    endfunction

endpackage

// File: rtl/sig_phase_ring.sv
// rtl/sig_phase_ring.sv - one-hot bank-select ring with clear and advance
module sig_phase_ring import sig_bank_pkg::*; #(
    parameter int N = sig_bank_pkg::BANKS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         adv,
    output logic [N-1:0] phase_oh
);

    localparam logic [N-1:0] RST_V = N'(PHASE_RST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            phase_oh <= RST_V;
        end else if (adv) begin
            phase_oh <= N'(rotl1(32'(phase_oh), N));
        end
    end

endmodule

// File: rtl/sig_bank_sequencer.sv
// rtl/sig_bank_sequencer.sv - loads signature banks and key, then scans banks with a compare strobe
module sig_bank_sequencer import sig_bank_pkg::*; #(
    parameter int WIDTH = sig_bank_pkg::WIDTH,
    parameter int BANKS = sig_bank_pkg::BANKS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   key_valid,
    input  logic [WIDTH-1:0]       key_data,
    output logic [BANKS*WIDTH-1:0] bank_q,
    output logic [WIDTH-1:0]       key_q,
    output logic [BANKS-1:0]       phase_oh,
    output logic                   cmp_strobe,
    output logic                   done,
    output logic                   busy
);

    localparam int PW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam logic [PW-1:0] LAST = PW'(BANKS - 1);

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] scnt;
    logic          last_scan;
    logic          ring_adv;
    logic          ring_clr;

    assign last_scan = (scnt == LAST);
    assign ring_adv  = (state == SCAN) && !abort && !last_scan;
    assign ring_clr  = abort || ((state == SCAN) && last_scan);

    sig_phase_ring #(.N(BANKS)) u_ring (
        .clk      (clk),
        .rst      (rst),
        .clr      (ring_clr),
        .adv      (ring_adv),
        .phase_oh (phase_oh)
    );

    // Status outputs are assigned alongside each transition so they stay registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            scnt       <= '0;
            bank_q     <= '0;
            key_q      <= '0;
            cmp_strobe <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            wr_ready   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                ptr        <= '0;
                scnt       <= '0;
                cmp_strobe <= 1'b0;
                busy       <= 1'b0;
                wr_ready   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= FILL;
                            ptr      <= '0;
                            busy     <= 1'b1;
                            wr_ready <= 1'b1;
                        end
                    end
                    FILL: begin
                        if (wr_valid) begin
                            bank_q[int'(ptr)*WIDTH +: WIDTH] <= wr_data;
                            if (ptr == LAST) begin
                                state    <= ARMED;
                                ptr      <= '0;
                                wr_ready <= 1'b0;
                            end else begin
                                ptr <= ptr + 1'b1;
                            end
                        end
                    end
                    ARMED: begin
                        if (key_valid) begin
                            key_q      <= key_data;
                            state      <= SCAN;
                            scnt       <= '0;
                            cmp_strobe <= 1'b1;
                        end
                    end
                    SCAN: begin
                        if (last_scan) begin
                            state      <= IDLE;
                            scnt       <= '0;
                            cmp_strobe <= 1'b0;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) $onehot(phase_oh));

endmodule

// File: tb/tb_sig_bank_sequencer.sv
// tb/tb_sig_bank_sequencer.sv - directed self-checking bench for sig_bank_sequencer
module tb_sig_bank_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_data;
    logic        key_valid;
    logic [9:0]  key_data;
    logic [29:0] bank_q;
    logic [9:0]  key_q;
    logic [2:0]  phase_oh;
    logic        cmp_strobe;
    logic        done;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sig_bank_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .bank_q     (bank_q),
        .key_q      (key_q),
        .phase_oh   (phase_oh),
        .cmp_strobe (cmp_strobe),
        .done       (done),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full load/key/scan sequence; returns while done is high so a caller may start again at once.
    task automatic run(input string tag, input logic [9:0] w0, input logic [9:0] w1,
                       input logic [9:0] w2, input logic [9:0] k, input int gap);
        logic [9:0] w [3];
        logic [2:0] exp_ph;
        int cyc;
        int strobes;
        int dcyc;
        w[0] = w0; w[1] = w1; w[2] = w2;
        cyc = 1;
        start = 1'b1; step(); start = 1'b0; cyc++;
        chk({tag, ".fill"}, {30'd0, busy, wr_ready}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    wr_valid = 1'b0; step(); cyc++;
                end
            end
            wr_valid = 1'b1; wr_data = w[i]; step(); cyc++;
        end
        wr_valid = 1'b0;
        chk({tag, ".banks"}, bank_q, {w2, w1, w0});
        chk({tag, ".armed_rdy"}, wr_ready, 0);
        key_valid = 1'b1; key_data = k; step(); cyc++; key_valid = 1'b0;
        chk({tag, ".key"}, key_q, k);
        strobes = 0;
        dcyc = -1;
        for (int t = 0; t < 12; t++) begin
            if (done) begin
                dcyc = cyc;
                break;
            end
            if (cmp_strobe) begin
                exp_ph = 3'b001 << strobes;
                chk({tag, ".phase"}, phase_oh, exp_ph);
                strobes++;
            end
            step(); cyc++;
        end
        chk({tag, ".strobes"}, strobes, 3);
        chk({tag, ".done_cyc"}, dcyc, 9 + 2 * gap);
        chk({tag, ".end"}, {phase_oh, cmp_strobe, busy}, {3'b001, 1'b0, 1'b0});
    endtask

    initial begin
        int dseen;
        rst = 1'b1; start = 1'b0; abort = 1'b0; wr_valid = 1'b0; wr_data = '0;
        key_valid = 1'b0; key_data = '0;
        step(); step();
        rst = 1'b0;
        chk("rst.bank", bank_q, 0);
        chk("rst.key", key_q, 0);
        chk("rst.ctl", {phase_oh, cmp_strobe, done, busy, wr_ready}, {3'b001, 4'b0000});

        run("full", 10'h155, 10'h2AA, 10'h3FF, 10'h2AA, 0);
        run("b2b", 10'h155, 10'h2AA, 10'h3FF, 10'h2AA, 0);
        step();
        run("stall", 10'h0F0, 10'h00F, 10'h1E1, 10'h123, 2);
        step();

        // Abort after two writes; the write offered alongside abort must be dropped.
        start = 1'b1; step(); start = 1'b0;
        wr_valid = 1'b1; wr_data = 10'h001; step();
        wr_data = 10'h002; step();
        wr_data = 10'h0AB; abort = 1'b1; step();
        abort = 1'b0; wr_valid = 1'b0;
        chk("abort.idle", {busy, wr_ready, cmp_strobe}, 0);
        chk("abort.banks", bank_q, {10'h1E1, 10'h002, 10'h001});
        dseen = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) dseen++;
            step();
        end
        chk("abort.nodone", dseen, 0);

        // Ignored inputs: key in FILL, write in ARMED, start in SCAN.
        start = 1'b1; step(); start = 1'b0;
        wr_valid = 1'b1; wr_data = 10'h011; step(); wr_valid = 1'b0;
        key_valid = 1'b1; key_data = 10'h077; step(); key_valid = 1'b0;
        chk("ign.key_fill", key_q, 10'h123);
        chk("ign.bank_fill", bank_q, {10'h1E1, 10'h002, 10'h011});
        chk("ign.still_fill", {busy, wr_ready}, 2'b11);
        wr_valid = 1'b1; wr_data = 10'h022; step();
        wr_data = 10'h033; step();
        wr_data = 10'h3C3; step(); wr_valid = 1'b0;
        chk("ign.wr_armed", bank_q, {10'h033, 10'h022, 10'h011});
        chk("ign.armed_ctl", {busy, wr_ready, cmp_strobe}, 3'b100);
        key_valid = 1'b1; key_data = 10'h100; step(); key_valid = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("ign.start_scan", {phase_oh, cmp_strobe, busy}, {3'b010, 2'b11});
        step(); step();
        chk("ign.done", done, 1);

        // Reset on the second strobe cycle clears everything, banks included.
        step();
        start = 1'b1; step(); start = 1'b0;
        wr_valid = 1'b1;
        wr_data = 10'h3A5; step();
        wr_data = 10'h05A; step();
        wr_data = 10'h1C7; step();
        wr_valid = 1'b0;
        key_valid = 1'b1; key_data = 10'h2D2; step(); key_valid = 1'b0;
        step();
        chk("rscan.second", {phase_oh, cmp_strobe}, {3'b010, 1'b1});
        rst = 1'b1; step(); rst = 1'b0;
        chk("rscan.bank", bank_q, 0);
        chk("rscan.key", key_q, 0);
        chk("rscan.ctl", {phase_oh, cmp_strobe, done, busy, wr_ready}, {3'b001, 4'b0000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sig_bank_sequencer.md
# sig_bank_sequencer

Write-side companion to the signature compare cone. Loads three 10-bit signature banks and a 10-bit reference key, then drives a one-hot bank-select phase and a compare strobe that the compare logic consumes, one bank per cycle. Sits between the test-control interface and the compare/hold register: it produces every input the compare cone reads.

## Interface
- `WIDTH`, 10: bits per bank word and per key.
- `BANKS`, 3: number of banks; fixes the phase one-hot width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE.
- `abort`  in  1  return to IDLE from any state; bank and key contents kept.
- `wr_valid`  in  1  bank word offered.
- `wr_ready`  out  1  high only in FILL.
- `wr_data`  in  WIDTH  bank word.
- `key_valid`  in  1  key offered; accepted only in ARMED.
- `key_data`  in  WIDTH  reference key.
- `bank_q`  out  BANKS*WIDTH  registered bank words; bank 0 in the LSBs.
- `key_q`  out  WIDTH  registered key.
- `phase_oh`  out  BANKS  one-hot bank select.
- `cmp_strobe`  out  1  compare enable; consumer updates its flag when high and holds when low.
- `done`  out  1  one-cycle pulse at the end of a scan.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, FILL, ARMED, SCAN.
- **IDLE**
  - `start` -> FILL; write pointer cleared to 0.
- **FILL**
  - A word is accepted on `wr_valid & wr_ready`. It is written to `bank[ptr]` and `ptr` increments.
  - The write that lands in bank BANKS-1 moves the FSM to ARMED.
  - Cycles with `wr_valid` low hold `ptr`. There is no timeout.
- **ARMED**
  - `key_valid` loads `key_q` and moves the FSM to SCAN.
  - `wr_valid` is ignored here.
- **SCAN**
  - Lasts exactly BANKS cycles. `cmp_strobe` is 1 on each of them.
  - `phase_oh` is 001, 010, 100 on successive cycles.
  - After the last cycle: `done` is 1 for one cycle, `phase_oh` returns to 001, and the FSM goes to IDLE.
- **Outside SCAN**
  - `phase_oh` is held at 001 and `cmp_strobe` is 0.
- **Abort and priority**
  - `abort` has priority over every other input.
  - It takes effect at the next edge: state -> IDLE, `ptr` -> 0, `phase_oh` -> 001, `cmp_strobe` -> 0, `done` -> 0.
  - A write or key load presented in the same cycle as `abort` is dropped.
- **Ignored inputs**
  - `start` outside IDLE is ignored.
  - `key_valid` outside ARMED is ignored.
- **Retention and invariants**
  - A new load overwrites the banks in order 0..BANKS-1.
  - Banks not yet rewritten keep their old contents.
  - `phase_oh` is one-hot in every cycle. Any non-one-hot value is a design error and is flagged by an assertion.

## Timing
- **Reset values**: `bank_q` 0, `key_q` 0, `phase_oh` 001, `cmp_strobe` 0, `done` 0, `busy` 0, `wr_ready` 0, state IDLE.
- **Reset mid-operation**: clears all of the above, including bank contents. `abort` does not clear bank contents.
- **Latency**
  - Accepted write visible on `bank_q` at the next edge.
  - Key visible on `key_q` at the next edge, which is also the first SCAN cycle.
  - So `key_q` is already valid when `cmp_strobe` first rises.
- **Outputs**: all outputs are registered; there are no combinational paths from input to output.
- **`wr_ready`**: a function of state only, so it does not depend on `wr_valid`.
- **Minimum cycle counts** (`start` to `done`, with input gaps of zero cycles):
  - 1 cycle IDLE->FILL.
  - BANKS write cycles.
  - 1 key cycle.
  - BANKS scan cycles.
  - `done` on the following cycle.
  - With the default BANKS = 3 this is 9 cycles.
- **Back-to-back runs**: `start` in the cycle `done` is high is honoured, because the FSM is already in IDLE.

## Structure
- Shared package `sig_bank_pkg`:
  - state enum: IDLE, FILL, ARMED, SCAN.
  - `WIDTH` and `BANKS` defaults.
  - `PHASE_RST` = 001.
  - Helper function for the one-hot rotate.
- Natural sub-module `sig_phase_ring`:
  - BANKS-bit one-hot ring.
  - Ports: `clk`, `rst`, `clr`, `adv`, `phase_oh`.
  - The FSM drives `adv` during SCAN and `clr` on abort or scan end.
- Top level holds the FSM, write pointer, scan counter, bank registers and key register.

## Test plan
- **Full run**:
  - Stimulus: `start`; writes 0x155, 0x2AA, 0x3FF; key 0x2AA.
  - Required: `bank_q` = {0x3FF, 0x2AA, 0x155}. `cmp_strobe` high for exactly 3 cycles with `phase_oh` 001/010/100. `done` 1 cycle later. Total 9 cycles.
- **Stalled writes**:
  - Stimulus: `wr_valid` low 2 cycles between each of the 3 writes.
  - Required: `ptr` holds during gaps; banks correct; `done` at cycle 13.
- **Abort in FILL**:
  - Stimulus: abort after 2 writes (0x001, 0x002).
  - Required: IDLE next cycle; bank0=0x001, bank1=0x002, bank2 unchanged; `done` never asserted.
- **Reset in SCAN**:
  - Stimulus: `rst` on the second strobe cycle.
  - Required: next cycle banks/key 0, `phase_oh` 001, `cmp_strobe` 0, `busy` 0.
- **Ignored inputs**:
  - Stimulus: `key_valid` in FILL; `wr_valid` in ARMED; `start` in SCAN.
  - Required: no state or register change.
- **Back-to-back**:
  - Stimulus: `start` coincident with `done`.
  - Required: FILL next cycle; second run completes identically.
